// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks one active-low column at a time, samples the
// synchronized rows once per column dwell and debounces each of the 12 keys.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk_raw,
    input  logic        rst_n,
    input  logic [2:0]  row_n,
    output logic [3:0]  col_n,
    output logic [11:0] keystroke,
    output logic [11:0] key_down
);

    localparam int unsigned     DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]      DEB_TARGET = 3'(DEBOUNCE_SCANS);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } phase_t;

    phase_t            state_r, state_s;
    logic [2:0]        row_meta_r, row_sync_r;
    logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
    logic [1:0]        col_idx_r, col_idx_s;
    logic [3:0]        col_n_r, col_n_s;
    logic [11:0]       keystroke_r, keystroke_s;
    logic [11:0]       key_down_r, key_down_s;
    logic [11:0][2:0]  deb_cnt_r, deb_cnt_s;
    logic [11:0]       col_mask_s;
    logic [11:0]       raw_s;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            row_meta_r <= 3'b111;
            row_sync_r <= 3'b111;
        end else begin
            row_meta_r <= row_n;
            row_sync_r <= row_meta_r;
        end
    end

    // Phase state register
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            state_r <= ST_SETTLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Dwell counter, phase and column sequencing
    always_comb begin
        div_cnt_s = (div_cnt_r == DIV_LAST) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        state_s   = (div_cnt_s == DIV_LAST) ? ST_SAMPLE : ST_SETTLE;
        case (state_r)
            ST_SAMPLE: col_idx_s = col_idx_r + 2'd1;
            ST_SETTLE: col_idx_s = col_idx_r;
            default:   col_idx_s = col_idx_r;
        endcase
        col_n_s = ~(4'b0001 << col_idx_s);
    end

    // Key-slot mask of the column currently being driven
    always_comb begin
        case (col_idx_r)
            2'd0:    col_mask_s = 12'b000_000_000_111;
            2'd1:    col_mask_s = 12'b000_000_111_000;
            2'd2:    col_mask_s = 12'b000_111_000_000;
            2'd3:    col_mask_s = 12'b111_000_000_000;
            default: col_mask_s = 12'b000_000_000_000;
        endcase
        raw_s = ~{row_sync_r, row_sync_r, row_sync_r, row_sync_r};
    end

    // Per-key debounce: a key toggles once DEBOUNCE_SCANS disagreeing samples arrive in a row
    always_comb begin
        keystroke_s = keystroke_r;
        deb_cnt_s   = deb_cnt_r;
        for (int k = 0; k < 12; k++) begin
            if ((state_r == ST_SAMPLE) && col_mask_s[4'(k)]) begin
                if (raw_s[4'(k)] == keystroke_r[4'(k)]) begin
                    deb_cnt_s[4'(k)] = 3'd0;
                end else if ((deb_cnt_r[4'(k)] + 3'd1) == DEB_TARGET) begin
                    keystroke_s[4'(k)] = ~keystroke_r[4'(k)];
                    deb_cnt_s[4'(k)]   = 3'd0;
                end else begin
                    deb_cnt_s[4'(k)] = deb_cnt_r[4'(k)] + 3'd1;
                end
            end else begin
                deb_cnt_s[4'(k)] = deb_cnt_r[4'(k)];
            end
        end
        key_down_s = keystroke_s & ~keystroke_r;
    end

    // Scan, debounce and output registers
    always_ff @(posedge clk_raw) begin
        if (!rst_n) begin
            div_cnt_r   <= {DIV_W{1'b0}};
            col_idx_r   <= 2'd0;
            col_n_r     <= 4'b1110;
            keystroke_r <= 12'h000;
            key_down_r  <= 12'h000;
            deb_cnt_r   <= '0;
        end else begin
            div_cnt_r   <= div_cnt_s;
            col_idx_r   <= col_idx_s;
            col_n_r     <= col_n_s;
            keystroke_r <= keystroke_s;
            key_down_r  <= key_down_s;
            deb_cnt_r   <= deb_cnt_s;
        end
    end

    assign col_n     = col_n_r;
    assign keystroke = keystroke_r;
    assign key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows from the
// column drive; a time-based reference predicts debounced state every cycle.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;

    logic        clk_raw = 1'b0;
    logic        rst_n   = 1'b0;
    logic [2:0]  row_n;
    logic [3:0]  col_n;
    logic [11:0] keystroke;
    logic [11:0] key_down;
    logic [11:0] pressed = 12'h000;

    logic [11:0] ks_m;
    int          cnt_m [12];
    logic [11:0] hist [4];
    int          kd_seen [12];
    int          p;
    int          errors = 0;
    int          checks = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk_raw   (clk_raw),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .keystroke (keystroke),
        .key_down  (key_down)
    );

    always #5 clk_raw = ~clk_raw;

    // Passive keypad: a held key shorts its row to its column when that column is low
    assign row_n = ~(({3{~col_n[0]}} & pressed[2:0])  | ({3{~col_n[1]}} & pressed[5:3]) |
                     ({3{~col_n[2]}} & pressed[8:6])  | ({3{~col_n[3]}} & pressed[11:9]));

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        for (int k = 0; k < 12; k++) kd_seen[4'(k)] = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk_raw);
        #1;
        check("rst_col_n", {8'h00, col_n}, 12'h00E);
        check("rst_keystroke", keystroke, 12'h000);
        check("rst_key_down", key_down, 12'h000);
        rst_n = 1'b1;
        ks_m  = 12'h000;
        for (int k = 0; k < 12; k++) cnt_m[4'(k)] = 0;
        p = 0;
    endtask

    // One clock: the sample at the end of each dwell sees the keys as they were two cycles earlier
    task automatic tick();
        logic [11:0] old;
        logic [11:0] smp;
        logic [11:0] kd_m;
        logic [3:0]  ecol;
        int          col;
        hist[2'(p % 4)] = pressed;
        @(posedge clk_raw);
        #1;
        kd_m = 12'h000;
        if (p % SD == SD - 1) begin
            col = (p / SD) % 4;
            smp = hist[2'((p - 2) % 4)];
            old = ks_m;
            for (int r = 0; r < 3; r++) begin
                int k;
                k = col * 3 + r;
                if (smp[4'(k)] == ks_m[4'(k)]) begin
                    cnt_m[4'(k)] = 0;
                end else begin
                    cnt_m[4'(k)]++;
                    if (cnt_m[4'(k)] == DB) begin
                        ks_m[4'(k)]  = ~ks_m[4'(k)];
                        cnt_m[4'(k)] = 0;
                    end
                end
            end
            kd_m = ks_m & ~old;
        end
        p++;
        ecol = 4'b0001 << ((p / SD) % 4);
        ecol = ~ecol;
        check("col_n", {8'h00, col_n}, {8'h00, ecol});
        check("keystroke", keystroke, ks_m);
        check("key_down", key_down, kd_m);
        for (int k = 0; k < 12; k++) if (key_down[4'(k)] === 1'b1) kd_seen[4'(k)]++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 16 && (p % 16) != phase; i++) tick();
    endtask

    initial begin
        int total;
        clear_seen();
        do_reset(3);
        run(40);

        // single press of key 5 held three frames
        pressed = 12'h020;
        clear_seen();
        run(36);
        check("press_k5", keystroke, 12'h020);
        run(12);
        check("press_k5_pulses", 12'(kd_seen[5]), 12'd1);

        // release: clears after two samples, no strobe
        pressed = 12'h000;
        clear_seen();
        run(48);
        check("release_k5", keystroke, 12'h000);
        check("release_k5_pulses", 12'(kd_seen[5]), 12'd0);

        // glitch: key 5 visible to a single column-1 sample only
        align(4);
        clear_seen();
        pressed = 12'h020;
        run(4);
        pressed = 12'h000;
        run(32);
        check("glitch_ks", keystroke, 12'h000);
        check("glitch_pulses", 12'(kd_seen[5]), 12'd0);

        // multi-key press 0, 8, 11
        clear_seen();
        pressed = 12'h901;
        run(64);
        check("multi_ks", keystroke, 12'h901);
        check("multi_k0", 12'(kd_seen[0]), 12'd1);
        check("multi_k8", 12'(kd_seen[8]), 12'd1);
        check("multi_k11", 12'(kd_seen[11]), 12'd1);
        pressed = 12'h000;
        run(48);

        // reset in the middle of debouncing key 3, key held throughout
        align(4);
        pressed = 12'h008;
        run(4);
        do_reset(1);
        run(8);
        check("rstmid_one_sample", keystroke, 12'h000);
        run(16);
        check("rstmid_two_samples", keystroke, 12'h008);
        pressed = 12'h000;
        run(48);

        // random key patterns with random hold times and occasional resets
        for (int i = 0; i < 40; i++) begin
            pressed = 12'($urandom);
            run($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
        end
        pressed = 12'h000;
        run(48);
        check("random_final_idle", keystroke, 12'h000);

        total = 0;
        for (int k = 0; k < 12; k++) total += kd_seen[4'(k)];
        check("random_strobes_seen", 12'(total > 0), 12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
